// File: rtl/ring_flit_pkg.sv
// rtl/ring_flit_pkg.sv - shared flit width, ctrl encodings and FSM state type for the dc ring ports
package ring_flit_pkg;

    localparam int FLIT_W    = 16;
    localparam int MAX_FLITS = 11;
    localparam int CNT_W     = 4;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } flit_state_t;

endpackage

// File: rtl/dc_upload_flit_mux.sv
// rtl/dc_upload_flit_mux.sv - picks flit number i_cnt out of the latched message, head flit at the top
module dc_upload_flit_mux #(
    parameter int MAX_FLITS = ring_flit_pkg::MAX_FLITS
) (
    input  logic [ring_flit_pkg::FLIT_W*MAX_FLITS-1:0] i_msg,
    input  logic [ring_flit_pkg::CNT_W-1:0]            i_cnt,
    output logic [ring_flit_pkg::FLIT_W-1:0]           o_flit
);
    import ring_flit_pkg::*;

    always_comb begin
        o_flit = '0;
        for (int i = 0; i < MAX_FLITS; i++) begin
            if (i_cnt == CNT_W'(i)) begin
                o_flit = i_msg[FLIT_W*(MAX_FLITS-i)-1 -: FLIT_W];
            end
        end
    end

endmodule

// File: rtl/dc_upload.sv
// rtl/dc_upload.sv - serialises a data-cache message onto the OUT_local FIFO one flit per cycle
// Optional DC_UPLOAD_BACK2BACK_EN: accept the next message on the tail cycle.
module dc_upload #(
    parameter int MAX_FLITS = ring_flit_pkg::MAX_FLITS
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ring_flit_pkg::FLIT_W*MAX_FLITS-1:0] dc_flits_in,
    input  logic                                       v_dc_flits_in,
    input  logic [ring_flit_pkg::CNT_W-1:0]            dc_flits_max,
    input  logic                                       out_fifo_full,
    output logic [ring_flit_pkg::FLIT_W-1:0]           dc_flit_out,
    output logic                                       v_dc_flit_out,
    output logic [1:0]                                 dc_ctrl_out,
    output logic                                       dc_upload_state
);
    import ring_flit_pkg::*;

    localparam int                MSG_W    = FLIT_W*MAX_FLITS;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(MAX_FLITS-1);

    flit_state_t        r_state;
    flit_state_t        w_state_nxt;
    logic [MSG_W-1:0]   r_msg;
    logic [CNT_W-1:0]   r_max;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_max_clamp;
    logic [FLIT_W-1:0]  w_mux_flit;
    logic [FLIT_W-1:0]  w_flit;
    logic [1:0]         w_ctrl;
    logic               w_valid;
    logic               w_busy;
    logic               w_load;
    logic               w_last;

    assign w_max_clamp = (dc_flits_max > LAST_IDX) ? LAST_IDX : dc_flits_max;

    dc_upload_flit_mux #(
        .MAX_FLITS (MAX_FLITS)
    ) u_flit_mux (
        .i_msg  (r_msg),
        .i_cnt  (r_cnt),
        .o_flit (w_mux_flit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        w_flit      = '0;
        w_ctrl      = CTRL_NONE;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (v_dc_flits_in) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_busy  = 1'b1;
                w_valid = !out_fifo_full;
                w_flit  = w_mux_flit;
                // a single-flit message stays HEAD; its length comes from the command field
                if (r_cnt == '0) begin
                    w_ctrl = CTRL_HEAD;
                end else if (r_cnt == r_max) begin
                    w_ctrl = CTRL_TAIL;
                end else begin
                    w_ctrl = CTRL_BODY;
                end
                w_last = w_valid && (r_cnt == r_max);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
`ifdef DC_UPLOAD_BACK2BACK_EN
                    // drop busy on the tail cycle so the cache can present its next message now
                    w_busy = 1'b0;
                    if (v_dc_flits_in) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_msg   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_msg <= dc_flits_in;
                r_max <= w_max_clamp;
                r_cnt <= '0;
            end else if (w_last) begin
                r_cnt <= '0;
            end else if (w_valid) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dc_flit_out     = w_flit;
    assign v_dc_flit_out   = w_valid;
    assign dc_ctrl_out     = w_ctrl;
    assign dc_upload_state = w_busy;

endmodule

// File: tb/tb_dc_upload.sv
// tb/tb_dc_upload.sv - directed and random checks of dc_upload against a flit-queue reference model
module tb_dc_upload;

`ifdef DC_UPLOAD_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [175:0] dc_flits_in;
    logic         v_dc_flits_in;
    logic [3:0]   dc_flits_max;
    logic         out_fifo_full;
    logic [15:0]  dc_flit_out;
    logic         v_dc_flit_out;
    logic [1:0]   dc_ctrl_out;
    logic         dc_upload_state;

    dc_upload dut (
        .clk             (clk),
        .rst             (rst),
        .dc_flits_in     (dc_flits_in),
        .v_dc_flits_in   (v_dc_flits_in),
        .dc_flits_max    (dc_flits_max),
        .out_fifo_full   (out_fifo_full),
        .dc_flit_out     (dc_flit_out),
        .v_dc_flit_out   (v_dc_flit_out),
        .dc_ctrl_out     (dc_ctrl_out),
        .dc_upload_state (dc_upload_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [17:0]  exp_q[$];
    logic [175:0] pend_d[$];
    logic [3:0]   pend_m[$];
    bit auto_cache = 1'b0;
    int cyc_no = 0;
    int n_valid, n_tail, n_busy, first_v, last_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_valid = 0; n_tail = 0; n_busy = 0; first_v = -1; last_v = -1;
    endtask

    task automatic push_msg(input logic [175:0] d, input logic [3:0] m);
        int n;
        logic [175:0] sh;
        logic [1:0] c;
        n = ((m > 4'd10) ? 10 : int'(m)) + 1;
        for (int k = 0; k < n; k++) begin
            sh = d << (16*k);
            c  = (k == 0) ? 2'b01 : ((k == n-1) ? 2'b11 : 2'b10);
            exp_q.push_back({c, sh[175:160]});
        end
    endtask

    task automatic check_model();
        bit exp_v, tail_now, exp_busy, accept;
        int qs;
        qs       = exp_q.size();
        exp_v    = (qs > 0) && !out_fifo_full;
        tail_now = exp_v && (qs == 1);
        exp_busy = (qs > 0) && !(B2B && tail_now);
        chk("valid", 32'(v_dc_flit_out), 32'(exp_v));
        chk("busy", 32'(dc_upload_state), 32'(exp_busy));
        if (qs > 0) begin
            chk("flit", 32'(dc_flit_out), 32'(exp_q[0][15:0]));
            chk("ctrl", 32'(dc_ctrl_out), 32'(exp_q[0][17:16]));
        end else begin
            chk("idle_flit", 32'(dc_flit_out), 32'd0);
            chk("idle_ctrl", 32'(dc_ctrl_out), 32'd0);
        end
        if (v_dc_flit_out) begin
            n_valid++;
            if (first_v < 0) first_v = cyc_no;
            last_v = cyc_no;
            if (dc_ctrl_out == 2'b11) n_tail++;
        end
        if (dc_upload_state) n_busy++;
        if (exp_v) void'(exp_q.pop_front());
        accept = v_dc_flits_in && ((qs == 0) || (B2B && tail_now));
        if (accept) begin
            push_msg(dc_flits_in, dc_flits_max);
            if (auto_cache && pend_d.size() > 0) begin
                void'(pend_d.pop_front());
                void'(pend_m.pop_front());
            end
        end
    endtask

    task automatic cyc(input logic f);
        out_fifo_full = f;
        #1;
        if (auto_cache) begin
            if (!dc_upload_state && pend_d.size() > 0) begin
                dc_flits_in   = pend_d[0];
                dc_flits_max  = pend_m[0];
                v_dc_flits_in = 1'b1;
            end else begin
                v_dc_flits_in = 1'b0;
            end
        end
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
        if (!auto_cache) v_dc_flits_in = 1'b0;
        cyc_no++;
    endtask

    task automatic present(input logic [175:0] d, input logic [3:0] m);
        dc_flits_in   = d;
        dc_flits_max  = m;
        v_dc_flits_in = 1'b1;
    endtask

    function automatic logic [175:0] rand_msg();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[175:0];
    endfunction

    logic [175:0] msg;
    int guard;

    initial begin
        rst = 1'b1; dc_flits_in = '0; v_dc_flits_in = 1'b0; dc_flits_max = '0; out_fifo_full = 1'b0;
        #3;
        chk("rst_valid", 32'(v_dc_flit_out), 32'd0);
        chk("rst_busy", 32'(dc_upload_state), 32'd0);
        chk("rst_flit", 32'(dc_flit_out), 32'd0);
        chk("rst_ctrl", 32'(dc_ctrl_out), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // scenario 1: 11-flit message, words A000+k
        for (int k = 0; k < 11; k++) msg[175-16*k -: 16] = 16'hA000 + 16'(k);
        clr_stats();
        present(msg, 4'd10);
        for (int i = 0; i < 13; i++) cyc(1'b0);
        chk("s1_nvalid", 32'(n_valid), 32'd11);
        chk("s1_ntail", 32'(n_tail), 32'd1);
        chk("s1_nbusy", 32'(n_busy), B2B ? 32'd10 : 32'd11);
        chk("s1_span", 32'(last_v - first_v + 1), 32'd11);

        // scenario 2: 3 flits with a stall on the second busy cycle
        clr_stats();
        present(rand_msg(), 4'd2);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0);
        chk("s2_nvalid", 32'(n_valid), 32'd3);
        chk("s2_nbusy", 32'(n_busy), B2B ? 32'd3 : 32'd4);

        // scenario 3: single flit 1234
        msg = '0; msg[175:160] = 16'h1234;
        clr_stats();
        present(msg, 4'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        chk("s3_nvalid", 32'(n_valid), 32'd1);
        chk("s3_ntail", 32'(n_tail), 32'd0);

        // scenario 4: new data pulsed mid-message is ignored
        clr_stats();
        present(rand_msg(), 4'd2);
        cyc(1'b0);
        cyc(1'b0);
        present(rand_msg(), 4'd5);
        for (int i = 0; i < 4; i++) cyc(1'b0);
        chk("s4_nvalid", 32'(n_valid), 32'd3);

        // scenario 5: reset after flit 4 of 11
        clr_stats();
        present(rand_msg(), 4'd10);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        chk("s5_nvalid_pre", 32'(n_valid), 32'd4);
        rst = 1'b1;
        #1;
        chk("s5_rst_valid", 32'(v_dc_flit_out), 32'd0);
        chk("s5_rst_busy", 32'(dc_upload_state), 32'd0);
        chk("s5_rst_flit", 32'(dc_flit_out), 32'd0);
        chk("s5_rst_ctrl", 32'(dc_ctrl_out), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b0);
        chk("s5_ntail_after_rst", 32'(n_tail), 32'd0);
        clr_stats();
        present(rand_msg(), 4'd2);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        chk("s5_next_nvalid", 32'(n_valid), 32'd3);

        // scenario 6: two 3-flit messages from an eager cache
        clr_stats();
        auto_cache = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pend_d.push_back(rand_msg());
            pend_m.push_back(4'd2);
        end
        for (int i = 0; i < 10; i++) cyc(1'b0);
        chk("s6_nvalid", 32'(n_valid), 32'd6);
        chk("s6_span", 32'(last_v - first_v + 1), B2B ? 32'd6 : 32'd7);

        // random messages, lengths including over-long counts, random stalls
        for (int i = 0; i < 30; i++) begin
            pend_d.push_back(rand_msg());
            pend_m.push_back(4'($urandom_range(0, 15)));
        end
        guard = 0;
        while ((pend_d.size() > 0 || exp_q.size() > 0) && guard < 3000) begin
            cyc($urandom_range(0, 3) == 0);
            guard++;
        end
        chk("rand_drained", 32'(pend_d.size() + exp_q.size()), 32'd0);
        auto_cache = 1'b0;
        v_dc_flits_in = 1'b0;
        cyc(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dc_upload.md
DC_UPLOAD -- requirements
Module: dc_upload

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter MAX_FLITS SHALL default to 11 and set the longest message in flits; message width = 16*MAX_FLITS.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port dc_flits_in, input, 176 bits: message from data cache; head flit in [175:160].
REQ-006 Port v_dc_flits_in, input, 1 bit: message and length valid.
REQ-007 Port dc_flits_max, input, 4 bits: flit count minus 1 (0 means 1 flit, 2 means 3, 10 means 11).
REQ-008 Port out_fifo_full, input, 1 bit: OUT_local FIFO cannot accept a flit this cycle.
REQ-009 Port dc_flit_out, output, 16 bits: current flit.
REQ-010 Port v_dc_flit_out, output, 1 bit: flit written into the FIFO this cycle.
REQ-011 Port dc_ctrl_out, output, 2 bits: 01 head, 10 body, 11 tail.
REQ-012 Port dc_upload_state, output, 1 bit: 1 = busy, cache must hold its message.

Function
REQ-013 FSM states SHALL be IDLE and BUSY.
REQ-014 In IDLE with v_dc_flits_in=1, the block SHALL latch dc_flits_in into msg_reg and min(dc_flits_max,10) into max_reg, clear cnt, and enter BUSY on the next edge.
REQ-015 dc_upload_state SHALL be 1 exactly while in BUSY.
REQ-016 In BUSY, dc_flit_out SHALL equal msg_reg[175-16*cnt -: 16]; the head flit leaves first.
REQ-017 v_dc_flit_out SHALL equal BUSY and not out_fifo_full, combinationally.
REQ-018 dc_ctrl_out SHALL be 01 when cnt=0, 11 when cnt=max_reg and max_reg>0, and 10 otherwise.
REQ-019 A single-flit message (max_reg=0) SHALL carry ctrl 01; the receiver decodes its length from the command field.
REQ-020 cnt SHALL increment only on cycles where v_dc_flit_out=1.
REQ-021 When out_fifo_full=1, the block SHALL hold cnt and the flit and deassert valid; it SHALL NOT drop or repeat a flit.
REQ-022 When the flit with cnt=max_reg is sent, the block SHALL return to IDLE and clear cnt.
REQ-023 v_dc_flits_in SHALL be ignored while BUSY; msg_reg SHALL NOT change mid-message.
REQ-024 A message of n flits SHALL take n cycles from the first BUSY cycle, plus one cycle per stalled cycle.
REQ-025 In IDLE, dc_flit_out SHALL be 0, v_dc_flit_out 0, and dc_ctrl_out 00.

Reset
REQ-026 Reset SHALL force IDLE, cnt=0, max_reg=0, msg_reg=0, and all outputs 0 immediately, without waiting for a clock edge.
REQ-027 Reset mid-message SHALL abandon the message; no tail flit SHALL be emitted afterwards.
REQ-028 The first message SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro DC_UPLOAD_BACK2BACK_EN, when defined, SHALL let the block latch a new message in the same cycle the tail is sent, going BUSY to BUSY with no idle cycle; dc_upload_state SHALL drop for that cycle so the cache can present the next message.
REQ-030 Without DC_UPLOAD_BACK2BACK_EN, there SHALL be at least one IDLE cycle between messages.

Structure
REQ-031 Package ring_flit_pkg SHALL hold the flit width (16), the ctrl encodings (HEAD=01, BODY=10, TAIL=11, NONE=00), MAX_FLITS, and the FSM state typedef; dc_download shares the same package.
REQ-032 A single sub-module, dc_upload_flit_mux, SHALL select the 16-bit slice from msg_reg by cnt; the FSM and counter stay in dc_upload.

Verification
REQ-033 Scenario 1: 11-flit wbrep with max=10, word k = 16'hA000+k, FIFO never full -> 11 consecutive valid flits A000..A00A; ctrl 01, then 10 x9, then 11; busy for 11 cycles.
REQ-034 Scenario 2: 3-flit shreq with max=2, and out_fifo_full=1 on the 2nd BUSY cycle -> flits 01,10,11 with one valid gap and no duplicated flit; 4 BUSY cycles.
REQ-035 Scenario 3: 1-flit nackrep with max=0, head 16'h1234 -> one flit 1234 with ctrl 01, then back to IDLE.
REQ-036 Scenario 4: v_dc_flits_in pulsed with new data during flit 2 of a 3-flit message -> the original message is sent intact and the new data is ignored.
REQ-037 Scenario 5: rst asserted after flit 4 of 11 -> outputs 0 immediately and no ctrl 11 is emitted; the next message starts with a clean head.
REQ-038 Scenario 6: two 3-flit messages presented back to back -> with DC_UPLOAD_BACK2BACK_EN, 6 consecutive valid cycles; without it, a 1-cycle gap between the messages.
